// File: rtl/toll_collector.sv
// Toll-booth controller: latches the rate class on arrival, collects coin credit,
// dispenses change one unit per cycle, opens the gate and raises an alarm on faults.
module toll_collector #(
  parameter int W           = 8,
  parameter int PRICE_HIGH  = 12,
  parameter int PRICE_MED   = 8,
  parameter int PRICE_LOW   = 4,
  parameter int GATE_CYCLES = 16,
  parameter int TIMEOUT     = 200
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         car,
  input  logic         high,
  input  logic         med,
  input  logic         low,
  input  logic         err,
  input  logic         coinv,
  input  logic [1:0]   coinval,
  input  logic         ack,
  output logic         gate,
  output logic         busy,
  output logic         alarm,
  output logic [W-1:0] due,
  output logic         chgp
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [W-1:0]  P_HIGH   = W'(PRICE_HIGH);
  localparam logic [W-1:0]  P_MED    = W'(PRICE_MED);
  localparam logic [W-1:0]  P_LOW    = W'(PRICE_LOW);
  localparam logic [GW-1:0] GATE_END = GW'(GATE_CYCLES - 1);
  localparam logic [7:0]    TMO_END  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHANGE,
    S_OPEN,
    S_ALARM
  } state_t;

  state_t          state;
  logic [W-1:0]    price;
  logic [W-1:0]    paid;
  logic [W-1:0]    change;
  logic            abort;
  logic [7:0]      timer;
  logic [GW-1:0]   gate_cnt;

  logic [3:0]      coin_units;
  logic [W:0]      sum_wide;
  logic [W-1:0]    paid_sum;
  logic [W-1:0]    paid_in;
  logic            class_ok;
  logic [W-1:0]    class_price;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    coin_units = 4'd1;
    unique case (coinval)
      2'd0: coin_units = 4'd1;
      2'd1: coin_units = 4'd2;
      2'd2: coin_units = 4'd5;
      2'd3: coin_units = 4'd10;
    endcase
  end

  always_comb begin
    class_ok    = 1'b0;
    class_price = '0;
    if (!err) begin
      unique case ({high, med, low})
        3'b100:  begin class_ok = 1'b1; class_price = P_HIGH; end
        3'b010:  begin class_ok = 1'b1; class_price = P_MED;  end
        3'b001:  begin class_ok = 1'b1; class_price = P_LOW;  end
        default: begin class_ok = 1'b0; class_price = '0;     end
      endcase
    end
  end

  // One spare bit catches the carry so credit clamps instead of wrapping.
  assign sum_wide = {1'b0, paid} + (W+1)'(coin_units);
  assign paid_sum = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
  assign paid_in  = coinv ? paid_sum : paid;

  // Owed amount is only meaningful while a payment is open or frozen by an alarm.
  assign due = ((state == S_COLLECT || state == S_ALARM) && (paid < price))
               ? (price - paid) : '0;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch sees the values from before this edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= S_IDLE;
      price    <= '0;
      paid     <= '0;
      change   <= '0;
      abort    <= 1'b0;
      timer    <= '0;
      gate_cnt <= '0;
      gate     <= 1'b0;
      busy     <= 1'b0;
      alarm    <= 1'b0;
      chgp     <= 1'b0;
    end else begin
      chgp <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (car) begin
            paid   <= '0;
            change <= '0;
            abort  <= 1'b0;
            timer  <= '0;
            busy   <= 1'b1;
            if (class_ok) begin
              price <= class_price;
              state <= S_COLLECT;
            end else begin
              price <= '0;
              alarm <= 1'b1;
              state <= S_ALARM;
            end
          end
        end

        S_COLLECT: begin
          if (paid >= price) begin
            if (paid > price) begin
              change <= paid - price;
              abort  <= 1'b0;
              state  <= S_CHANGE;
            end else begin
              gate     <= 1'b1;
              gate_cnt <= '0;
              state    <= S_OPEN;
            end
          end else if (!car) begin
            // Refund includes a coin landing in the same cycle the car leaves.
            if (paid_in == '0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              paid   <= paid_in;
              change <= paid_in;
              abort  <= 1'b1;
              state  <= S_CHANGE;
            end
          end else if (coinv) begin
            paid  <= paid_sum;
            timer <= '0;
          end else if (timer == TMO_END) begin
            alarm <= 1'b1;
            state <= S_ALARM;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        S_CHANGE: begin
          if (change != '0) begin
            chgp   <= 1'b1;
            change <= change - 1'b1;
          end else if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gate     <= 1'b1;
            gate_cnt <= '0;
            state    <= S_OPEN;
          end
        end

        S_OPEN: begin
          if (gate_cnt != GATE_END) begin
            gate_cnt <= gate_cnt + 1'b1;
          end else if (!car) begin
            gate  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_ALARM: begin
          if (ack) begin
            paid   <= '0;
            change <= '0;
            price  <= '0;
            alarm  <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          gate  <= 1'b0;
          busy  <= 1'b0;
          alarm <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toll_collector.sv
// Directed bench for toll_collector: hand-computed expectations for pricing,
// change, gate timing, alarms, refunds and mid-transaction reset.
module tb_toll_collector;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         nrst;
  logic         car, high, med, low, err;
  logic         coinv;
  logic [1:0]   coinval;
  logic         ack;
  logic         gate, busy, alarm, chgp;
  logic [W-1:0] due;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int gates  = 0;

  toll_collector #(
    .W(W), .PRICE_HIGH(12), .PRICE_MED(8), .PRICE_LOW(4),
    .GATE_CYCLES(16), .TIMEOUT(200)
  ) dut (
    .clk(clk), .nrst(nrst), .car(car), .high(high), .med(med), .low(low),
    .err(err), .coinv(coinv), .coinval(coinval), .ack(ack),
    .gate(gate), .busy(busy), .alarm(alarm), .due(due), .chgp(chgp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1ns later and tally pulses / open-gate cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (chgp) pulses++;
    if (gate) gates++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    car = 0; high = 0; med = 0; low = 0; err = 0;
    coinv = 0; coinval = 0; ack = 0;
  endtask

  task automatic wait_gate(input logic want, input int budget, input string tag);
    for (int i = 0; i < budget && gate !== want; i++) step();
    check(tag, 32'(gate), 32'(want));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy !== 1'b0; i++) step();
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic coin(input logic [1:0] code);
    coinv = 1; coinval = code;
    step();
    coinv = 0;
  endtask

  initial begin
    idle_inputs();
    nrst = 0;
    steps(2);
    check("rst_gate",  32'(gate),  0);
    check("rst_busy",  32'(busy),  0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_due",   32'(due),   0);
    check("rst_chgp",  32'(chgp),  0);
    nrst = 1;
    step();

    // Med (8): coins 10, 1, 5 -> change of 2, then 16 open cycles
    car = 1; med = 1;
    step();
    check("med_busy", 32'(busy), 1);
    check("med_due0", 32'(due), 8);
    pulses = 0; gates = 0;
    coinv = 1; coinval = 2'd3; step();
    check("med_due_after10", 32'(due), 0);
    coinval = 2'd0; step();
    coinval = 2'd2; step();
    coinv = 0;
    wait_gate(1'b1, 20, "med_gate_open");
    car = 0; med = 0;
    wait_gate(1'b0, 40, "med_gate_close");
    check("med_pulses", 32'(pulses), 2);
    check("med_gate_cycles", 32'(gates), 16);
    check("med_idle", 32'(busy), 0);

    // Low (4): two coins of 2 pay exactly; later coins ignored
    car = 1; low = 1;
    step();
    pulses = 0;
    coin(2'd1);
    check("low_due2", 32'(due), 2);
    coinv = 1; coinval = 2'd1; step();
    check("low_due0", 32'(due), 0);
    step();
    check("low_gate_direct", 32'(gate), 1);
    step();
    coinv = 0;
    steps(25);
    check("low_gate_held", 32'(gate), 1);
    check("low_pulses", 32'(pulses), 0);
    car = 0; low = 0;
    step();
    check("low_gate_shut", 32'(gate), 0);
    check("low_idle", 32'(busy), 0);

    // Classifier error and malformed class -> alarm, cleared by ack
    car = 1; err = 1;
    step();
    check("err_alarm", 32'(alarm), 1);
    check("err_busy", 32'(busy), 1);
    check("err_gate", 32'(gate), 0);
    car = 0; err = 0;
    ack = 1; step(); ack = 0;
    check("err_ack_alarm", 32'(alarm), 0);
    check("err_ack_busy", 32'(busy), 0);
    car = 1; high = 1; med = 1;
    step();
    check("multi_alarm", 32'(alarm), 1);
    car = 0; high = 0; med = 0;
    ack = 1; step(); ack = 0;
    check("multi_ack", 32'(alarm), 0);

    // High (12): one coin of 5 then timeout after 200 idle cycles
    car = 1; high = 1;
    step();
    coin(2'd2);
    check("tmo_due7", 32'(due), 7);
    steps(50);
    ack = 1; step(); ack = 0;
    check("tmo_ack_ignored", 32'(busy), 1);
    steps(148);
    check("tmo_not_yet", 32'(alarm), 0);
    step();
    check("tmo_alarm", 32'(alarm), 1);
    check("tmo_due_kept", 32'(due), 7);
    car = 0; high = 0;
    steps(3);
    check("tmo_due_still", 32'(due), 7);
    ack = 1; step(); ack = 0;
    check("tmo_cleared", 32'(alarm), 0);
    check("tmo_due_clear", 32'(due), 0);

    // High: coin 10 then car leaves with a coin of 1 -> refund 11
    car = 1; high = 1;
    step();
    pulses = 0; gates = 0;
    coin(2'd3);
    check("ref_due2", 32'(due), 2);
    car = 0; high = 0;
    coin(2'd0);
    wait_idle(40, "ref_idle");
    check("ref_pulses", 32'(pulses), 11);
    check("ref_no_gate", 32'(gates), 0);

    // Reset while 3 units of change are pending; car held re-arms afterwards
    car = 1; high = 1;
    step();
    coin(2'd3);
    coin(2'd2);
    step();
    pulses = 0;
    nrst = 0;
    step();
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_chgp", 32'(chgp), 0);
    check("rst_mid_gate", 32'(gate), 0);
    check("rst_mid_due", 32'(due), 0);
    nrst = 1;
    step();
    check("rearm_busy", 32'(busy), 1);
    check("rearm_due", 32'(due), 12);
    steps(5);
    check("rearm_no_chg", 32'(pulses), 0);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/toll_collector.md
Name: toll_collector

Overview:
Sequential toll-booth controller that sits after the rate classifier. It latches the one-hot rate class (High/Med/Low/Err) when a vehicle arrives and loads the matching price. It then accumulates coin credit, pays back any overpayment one unit per cycle, opens the gate and returns to idle. Classifier errors, malformed class codes and payment timeouts raise an alarm that an operator acknowledges.

Parameters:
W, 8, width of price/credit/change datapath (units of smallest coin)
PRICE_HIGH, 12, toll for High class
PRICE_MED, 8, toll for Med class
PRICE_LOW, 4, toll for Low class
GATE_CYCLES, 16, minimum cycles gate stays open
TIMEOUT, 200, idle cycles in COLLECT before alarm (must fit in 8 bits)

Ports:
CLK  in  1  system clock, all state on rising edge
nRST  in  1  synchronous active-low reset
Car  in  1  vehicle present in booth (level)
High  in  1  rate class High from classifier
Med  in  1  rate class Med
Low  in  1  rate class Low
Err  in  1  classifier error flag
CoinV  in  1  one-cycle coin-accepted strobe
CoinVal  in  2  coin value code: 0=1, 1=2, 2=5, 3=10 units
Ack  in  1  operator alarm acknowledge (one-cycle pulse)
Gate  out  1  gate open
Busy  out  1  transaction in progress (any state but IDLE)
Alarm  out  1  alarm state active
Due  out  W  remaining amount owed = max(Price-Paid, 0)
ChgP  out  1  one-unit change-dispense pulse

Behaviour:
- One clock; reset is synchronous and active-low. nRST=0 at a rising CLK edge -> state IDLE, Gate=0, Busy=0, Alarm=0, Due=0, ChgP=0, Price/Paid/Change/counters=0. Reset has the same effect in every state, including mid-COLLECT or mid-CHANGE. Pending change is discarded.
- All outputs are registered (Due is registered or derived only from registers).
- States: IDLE, COLLECT, CHANGE, OPEN, ALARM.
- IDLE: when Car=1, sample the class in the same cycle.
  - Exactly one of High/Med/Low=1 and Err=0 -> Price <= matching parameter, Paid <= 0, timer <= 0, next state COLLECT.
  - Err=1, or zero or more than one class bit set -> ALARM.
  - Coins arriving in IDLE are ignored.
- COLLECT:
  - Each CoinV adds the decoded value to Paid. Saturate at 2^W-1. The timer clears on each coin.
  - Due = Price-Paid while Paid<Price, else 0. It updates the cycle after the coin.
  - Once Paid>=Price (checked on the registered Paid): if Paid>Price -> Change <= Paid-Price, abort=0, go CHANGE; else go OPEN.
  - Car drops to 0 before payment completes -> Change <= Paid, abort=1, go CHANGE (full refund). If Paid=0, go IDLE directly.
  - Timer reaches TIMEOUT with no coin -> ALARM. Paid is retained in that case, with no refund.
  - Coin and Car-drop in the same cycle: the coin is counted first, and the refund includes it.
- CHANGE:
  - ChgP=1 for one cycle per unit, one unit every cycle. Change is decremented each pulse.
  - Coins are ignored.
  - When Change reaches 0 -> OPEN if abort=0, else IDLE. The gate stays shut on abort.
  - A change of N produces exactly N consecutive ChgP pulses.
- OPEN:
  - Gate=1. Counter counts GATE_CYCLES cycles.
  - Exit to IDLE only when the count is done and Car=0. Gate stays open while Car=1 after the count expires.
  - Gate returns to 0 the cycle IDLE is entered.
  - A new vehicle is not sampled until IDLE.
- ALARM:
  - Alarm=1, Gate=0, coins ignored.
  - Ack=1 -> IDLE with Paid, Change and Price cleared.
  - Ack arriving in any other state has no effect.
- Busy=1 in every state except IDLE.
- Arithmetic:
  - Paid addition is W+1 bits internally, then clamped.
  - Change = Paid-Price is computed only when Paid>=Price, so it never underflows.

Test Plan:
- Reset, then Car=1, Med=1, three coins coded 3 (10), 0 (1), 2 (5) -> after the first coin Due=0, Paid=10; CHANGE emits 2 ChgP pulses; Gate=1 for 16 cycles, then IDLE after Car=0.
- Car=1, Low=1, coin code 1 four times (2+2 = 4 after two coins) -> exact payment, 0 ChgP, OPEN directly; extra coins after OPEN are ignored.
- Car=1 with Err=1 (or High=Med=1) -> Alarm=1, Busy=1, Gate stays 0; Ack pulse -> IDLE, Alarm=0.
- Car=1, High=1, one coin of 5, then no coins for 200 cycles -> Alarm=1 at the TIMEOUT cycle; Due stays 7 until Ack.
- Car=1, High=1, coins 10 then Car=0 on the next cycle together with a coin of 1 -> refund of 11 ChgP pulses, Gate never opens, ends in IDLE.
- nRST=0 during CHANGE with 3 units pending -> next cycle all outputs 0, IDLE, no further ChgP; Car held high re-arms a fresh transaction after reset.
